// File: rtl/simon_sequence_player.sv
`default_nettype none
// ============================================================================
// Module   : simon_sequence_player
// Brief    : Simon sequencer: plays the generator's colour sequence on the LEDs,
//            then checks button presses against a replay of it. An input
//            timeout is added when SIMON_INPUT_TIMEOUT_EN is defined.
// Revision : 1.0
// ============================================================================
module simon_sequence_player #(
    parameter int MAX_LEN        = 32,
    parameter int LEN_W          = 6,
    parameter int SHOW_CYCLES    = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       rnd,
    input  logic [3:0]       btn,
    output logic             lfsr_step,
    output logic             lfsr_rerun,
    output logic [3:0]       led,
    output logic [LEN_W-1:0] level,
    output logic             busy,
    output logic             game_over,
    output logic             win
);

    localparam int c_cnt_max = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_SEED_SHOW = 4'd1,
        ST_SHOW_ON   = 4'd2,
        ST_SHOW_STEP = 4'd3,
        ST_SHOW_GAP  = 4'd4,
        ST_SEED_IN   = 4'd5,
        ST_WAIT_IN   = 4'd6,
        ST_IN_STEP   = 4'd7,
        ST_LOSE      = 4'd8,
        ST_WIN       = 4'd9
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   level_q, level_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;

`ifdef SIMON_INPUT_TIMEOUT_EN
    localparam int c_tmr_w = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_tmr_w-1:0] tmr_q, tmr_d;
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;
`endif

    logic [3:0]       w_colour;
    logic [LEN_W-1:0] w_idx_inc;
    logic             w_unused_rnd;

    assign w_colour     = 4'b0001 << rnd[1:0];
    assign w_idx_inc    = idx_q + LEN_W'(1);
    assign w_unused_rnd = ^rnd[3:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
`ifdef SIMON_INPUT_TIMEOUT_EN
            tmr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
`ifdef SIMON_INPUT_TIMEOUT_EN
            tmr_q   <= tmr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
`ifdef SIMON_INPUT_TIMEOUT_EN
        tmr_d   = tmr_q;
`endif
        case (state_q)
            ST_IDLE, ST_LOSE, ST_WIN: begin
                if (start) begin
                    state_d = ST_SEED_SHOW;
                    level_d = LEN_W'(1);
                end
            end
            ST_SEED_SHOW: begin
                idx_d   = '0;
                cnt_d   = '0;
                state_d = ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
                if (cnt_q == c_cnt_w'(SHOW_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_SHOW_STEP;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
            ST_SHOW_STEP: begin
                idx_d   = w_idx_inc;
                cnt_d   = '0;
                state_d = ST_SHOW_GAP;
            end
            ST_SHOW_GAP: begin
                if (cnt_q == c_cnt_w'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = (idx_q == level_q) ? ST_SEED_IN : ST_SHOW_ON;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
            ST_SEED_IN: begin
                idx_d   = '0;
                state_d = ST_WAIT_IN;
`ifdef SIMON_INPUT_TIMEOUT_EN
                tmr_d   = '0;
`endif
            end
            ST_WAIT_IN: begin
                // A press always wins over a timer expiring in the same cycle.
                if (btn != 4'd0) begin
                    if (btn == w_colour) begin
                        state_d = ST_IN_STEP;
`ifdef SIMON_INPUT_TIMEOUT_EN
                        tmr_d   = '0;
`endif
                    end else begin
                        state_d = ST_LOSE;
                    end
                end
`ifdef SIMON_INPUT_TIMEOUT_EN
                else if (tmr_q == c_tmr_w'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_LOSE;
                end else begin
                    tmr_d = tmr_q + c_tmr_w'(1);
                end
`endif
            end
            ST_IN_STEP: begin
                idx_d = w_idx_inc;
                if (w_idx_inc < level_q) begin
                    state_d = ST_WAIT_IN;
`ifdef SIMON_INPUT_TIMEOUT_EN
                    tmr_d   = '0;
`endif
                end else if (level_q == LEN_W'(MAX_LEN)) begin
                    state_d = ST_WIN;
                end else begin
                    level_d = level_q + LEN_W'(1);
                    state_d = ST_SEED_SHOW;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // rnd is the generator's own register output; led only gates it by state.
    assign led        = (state_q == ST_SHOW_ON) ? w_colour : 4'd0;
    assign lfsr_step  = (state_q == ST_SHOW_STEP) || (state_q == ST_IN_STEP);
    assign lfsr_rerun = (state_q == ST_SEED_SHOW) || (state_q == ST_SEED_IN);
    assign level      = level_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_LOSE) && (state_q != ST_WIN);
    assign game_over  = (state_q == ST_LOSE);
    assign win        = (state_q == ST_WIN);

endmodule
`default_nettype wire

// File: tb/tb_simon_sequence_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_sequence_player
// Brief    : Scoreboard bench for simon_sequence_player with a 16-bit LFSR
//            generator model (seed 16'hACE1; colours 1 then 0).
// Revision : 1.0
// ============================================================================
module tb_simon_sequence_player;

    localparam int          c_show    = 8;
    localparam int          c_gap     = 4;
    localparam int          c_period  = c_show + 1 + c_gap;
    localparam int          c_max_len = 2;
    localparam int          c_timeout = 16;
    localparam logic [15:0] c_seed    = 16'hACE1;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] btn   = 4'd0;
    logic [3:0] rnd;
    logic       lfsr_step, lfsr_rerun, busy, game_over, win;
    logic [3:0] led;
    logic [5:0] level;

    always #5 clk = ~clk;

    simon_sequence_player #(
        .MAX_LEN        (c_max_len),
        .LEN_W          (6),
        .SHOW_CYCLES    (c_show),
        .GAP_CYCLES     (c_gap),
        .TIMEOUT_CYCLES (c_timeout)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rnd        (rnd),
        .btn        (btn),
        .lfsr_step  (lfsr_step),
        .lfsr_rerun (lfsr_rerun),
        .led        (led),
        .level      (level),
        .busy       (busy),
        .game_over  (game_over),
        .win        (win)
    );

    // Generator model: Fibonacci LFSR, taps 16/14/13/11, shifting right.
    logic [15:0] lfsr_q = c_seed;
    always @(posedge clk) begin
        if (lfsr_rerun)
            lfsr_q <= c_seed;
        else if (lfsr_step)
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
    assign rnd = lfsr_q[3:0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       step;
        logic       rerun;
        logic [3:0] led;
    } ev_t;

    typedef struct {
        int         cyc;
        logic [5:0] level;
        logic       busy;
        logic       go;
        logic       win;
    } st_t;

    ev_t ev_q[$];
    st_t st_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    // Hand-derived: 16'hACE1 -> colour 1, one step -> 16'h5670 -> colour 0.
    function automatic logic [3:0] exp_led(input int i);
        return (i == 0) ? 4'b0010 : 4'b0001;
    endfunction

    always @(negedge clk) begin : monitor
        bit found;
        found = 1'b0;
        if (mon_en) begin
            for (int i = ev_q.size() - 1; i >= 0; i--) begin
                if (ev_q[i].cyc == cyc) begin
                    found = 1'b1;
                    checks++;
                    if (lfsr_step !== ev_q[i].step || lfsr_rerun !== ev_q[i].rerun ||
                        led !== ev_q[i].led) begin
                        errors++;
                        $display("FAIL event@%0d: got step=%b rerun=%b led=%b, expected step=%b rerun=%b led=%b",
                                 cyc, lfsr_step, lfsr_rerun, led,
                                 ev_q[i].step, ev_q[i].rerun, ev_q[i].led);
                    end
                    ev_q.delete(i);
                end
            end
            if (!found && (lfsr_step || lfsr_rerun || led != 4'd0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected@%0d: got step=%b rerun=%b led=%b, expected all 0",
                         cyc, lfsr_step, lfsr_rerun, led);
            end
            for (int i = st_q.size() - 1; i >= 0; i--) begin
                if (st_q[i].cyc == cyc) begin
                    checks++;
                    if (level !== st_q[i].level || busy !== st_q[i].busy ||
                        game_over !== st_q[i].go || win !== st_q[i].win) begin
                        errors++;
                        $display("FAIL status@%0d: got level=%0d busy=%b game_over=%b win=%b, expected level=%0d busy=%b game_over=%b win=%b",
                                 cyc, level, busy, game_over, win,
                                 st_q[i].level, st_q[i].busy, st_q[i].go, st_q[i].win);
                    end
                    st_q.delete(i);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push_ev(input int c, input logic s, input logic r, input logic [3:0] l);
        ev_t e;
        e = '{c, s, r, l};
        ev_q.push_back(e);
    endtask

    task automatic push_st(input int c, input logic [5:0] lv, input logic b,
                           input logic g, input logic w);
        st_t s;
        s = '{c, lv, b, g, w};
        st_q.push_back(s);
    endtask

    // Round whose SEED_SHOW cycle is r; returns the first WAIT_IN cycle.
    task automatic push_round(input int r, input int lvl, output int w);
        int base;
        push_ev(r, 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < lvl; i++) begin
            base = r + 1 + i * c_period;
            for (int k = 0; k < c_show; k++)
                push_ev(base + k, 1'b0, 1'b0, exp_led(i));
            push_ev(base + c_show, 1'b1, 1'b0, 4'd0);
        end
        push_ev(r + lvl * c_period + 1, 1'b0, 1'b1, 4'd0);
        w = r + lvl * c_period + 2;
        push_st(w, 6'(lvl), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic press(input logic [3:0] b);
        btn = b;
        tick();
        btn = 4'd0;
    endtask

    task automatic start_game(output int w);
        int t;
        t = cyc;
        start = 1'b1;
        push_st(t + 1, 6'd1, 1'b1, 1'b0, 1'b0);
        push_round(t + 1, 1, w);
        tick();
        start = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not reach its end, expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        int w, w2, t;
        tick();
        tick();
        reset  = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++)
            push_st(cyc + i, 6'd0, 1'b0, 1'b0, 1'b0);
        wait_until(cyc + 10);

        // Game 1: round 1 correct, round 2 wrong colour.
        start_game(w);
        wait_until(w);
        push_ev(w + 1, 1'b1, 1'b0, 4'd0);
        push_st(w + 2, 6'd2, 1'b1, 1'b0, 1'b0);
        press(4'b0010);
        push_round(w + 2, 2, w2);
        wait_until(w2);
        push_st(w2 + 1, 6'd2, 1'b0, 1'b1, 1'b0);
        push_st(w2 + 5, 6'd2, 1'b0, 1'b1, 1'b0);
        press(4'b0100);
        wait_until(w2 + 6);

        // Game 2: stray presses and start during playback/IN_STEP, then win.
        t = cyc;
        start_game(w);
        wait_until(t + 4);
        start = 1'b1;
        btn   = 4'b0010;
        tick();
        start = 1'b0;
        btn   = 4'b0001;
        tick();
        btn   = 4'd0;
        wait_until(w);
        push_ev(w + 1, 1'b1, 1'b0, 4'd0);
        press(4'b0010);
        btn = 4'b0100;
        push_round(w + 2, 2, w2);
        tick();
        btn = 4'd0;
        wait_until(w2);
        push_ev(w2 + 1, 1'b1, 1'b0, 4'd0);
        press(4'b0010);
        btn = 4'b0100;
        tick();
        btn = 4'd0;
        push_ev(w2 + 3, 1'b1, 1'b0, 4'd0);
        push_st(w2 + 4, 6'd2, 1'b0, 1'b0, 1'b1);
        push_st(w2 + 24, 6'd2, 1'b0, 1'b0, 1'b1);
        press(4'b0001);
        wait_until(w2 + 26);

        // Game 3: restart from WIN, multi-bit press loses.
        start_game(w);
        wait_until(w);
        push_st(w + 1, 6'd1, 1'b0, 1'b1, 1'b0);
        press(4'b0011);
        wait_until(w + 4);

`ifdef SIMON_INPUT_TIMEOUT_EN
        // Game 4: no press, timer expires 16 cycles after WAIT_IN entry.
        start_game(w);
        push_st(w + c_timeout - 1, 6'd1, 1'b1, 1'b0, 1'b0);
        push_st(w + c_timeout, 6'd1, 1'b0, 1'b1, 1'b0);
        wait_until(w + c_timeout + 4);
`endif

        tick();
        tick();
        foreach (ev_q[i]) begin
            checks++;
            errors++;
            $display("FAIL missing event@%0d: got nothing, expected step=%b rerun=%b led=%b",
                     ev_q[i].cyc, ev_q[i].step, ev_q[i].rerun, ev_q[i].led);
        end
        foreach (st_q[i]) begin
            checks++;
            errors++;
            $display("FAIL missing status@%0d: got nothing, expected level=%0d", st_q[i].cyc, st_q[i].level);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
